load_ctrl_ram: RTL
==================

Name: load_ctrl_ram

Overview:
- Read-side companion of the RAM store-merge path: runs load transactions (LB/LBU/LH/LHU/LW) against the word-wide data RAM.
- Issues one word read, or two word reads when the access crosses a word boundary.
- Waits the fixed RAM read latency, extracts the addressed byte, halfword or word and sign- or zero-extends it.
- Sits between the MEM stage (request/response handshake) and the data RAM read port.

Parameters:
- RD_LATENCY, 1, cycles from a ram_re pulse to valid ram_rdata; legal range 1..7.
- ADDR_W, 32, byte address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  1  load request present.
- req_ready  output  1  block can accept a request.
- addr  input  ADDR_W  byte address of the load.
- TYPE_B  input  1  byte access; TYPE_HB is also high when TYPE_B is high.
- TYPE_HB  input  1  byte or halfword access. TYPE_HB=0 means word access.
- UNSIGNED  input  1  1 = zero-extend, 0 = sign-extend; ignored for word access.
- ram_re  output  1  one-cycle read strobe.
- ram_addr  output  ADDR_W-2  word address for the read.
- ram_rdata  input  32  RAM word, little-endian (byte 0 = bits 7:0).
- dout  output  32  extended load result.
- dout_valid  output  1  dout holds a result.
- dout_ready  input  1  consumer accepts the result.
- busy  output  1  a transaction is in progress (every state except IDLE).

Behaviour:
- Reset values: req_ready=0 during the reset cycle and 1 after; ram_re=0, ram_addr=0, dout=0, dout_valid=0, busy=0. Reset also clears the FSM, the latency counter and captured words.
- Reset mid-transaction abandons the transaction. Any later ram_rdata from the abandoned read is ignored, and no dout_valid is produced for it.
- Decode:
  - size: byte if TYPE_B; halfword if TYPE_HB && !TYPE_B; word otherwise.
  - o = addr[1:0].
  - split = (half && o==3) || (word && o!=0).
- Request and read timing:
  - A request is accepted when req_valid && req_ready. All request inputs are latched on accept.
  - req_ready=1 only in IDLE, so there is exactly one transaction in flight.
- FSM states and transitions:
  - IDLE: on accept -> RD0.
  - RD0: drive ram_re=1 and ram_addr=addr[ADDR_W-1:2] for exactly one cycle. -> WAIT0.
  - WAIT0: count RD_LATENCY cycles, then capture ram_rdata into w0. -> RD1 if split, else -> DONE.
  - RD1: drive ram_re=1 and ram_addr=addr[ADDR_W-1:2]+1 for one cycle. The word address wraps modulo 2^(ADDR_W-2), so byte address 0xFFFFFFFF reads word 0. -> WAIT1.
  - WAIT1: count RD_LATENCY cycles, then capture ram_rdata into w1. -> DONE.
  - DONE: dout_valid=1 and dout stays stable until dout_ready. When dout_ready=1: dout_valid drops next cycle -> IDLE.
- Latency, with accept at cycle T:
  - ram_re is high in cycle T+1.
  - Non-split: dout_valid first high at T+2+RD_LATENCY.
  - Split: second ram_re at T+2+RD_LATENCY; dout_valid first high at T+3+2*RD_LATENCY.
  - A new request cannot be accepted in the cycle dout is consumed. It can be accepted from the following cycle (IDLE).
- Extraction:
  - Form the 64-bit value c = {w1, w0}, with w1 = 0 when the access is not split.
  - Compute s = c >> (8*o).
  - byte: dout = {24{~UNSIGNED & s[7]}, s[7:0]}.
  - half: dout = {16{~UNSIGNED & s[15]}, s[15:0]}.
  - word: dout = s[31:0].
- Unlisted TYPE_B=1, TYPE_HB=0 is treated as byte.
- ram_rdata is sampled only at the two capture points; it is don't-care in every other cycle.

Test Plan:
1. RD_LATENCY=1, LW at 0x100, RAM word 0x40 = 0xDEADBEEF.
   -> ram_re at T+1 with ram_addr=0x40; dout=0xDEADBEEF with dout_valid at T+3.
2. LB at 0x103, word = 0x80112233.
   -> dout=0xFFFFFF80.
   LBU, same address -> dout=0x00000080.
3. LHU at 0x0FF, split: word 0x3F = 0xAABBCCDD, word 0x40 = 0x11223344.
   -> two ram_re pulses (addr 0x3F, then 0x40); dout=0x000044AA at T+5.
   LH, same address -> dout=0x000044AA (bit 15 = 0).
4. LW at 0x002 with words 0xAABBCCDD / 0x11223344.
   -> dout=0x3344AABB.
   Same load at 0xFFFFFFFE -> second ram_addr wraps to 0x0.
5. Hold dout_ready=0 for 4 cycles after dout_valid.
   -> dout_valid and dout stay constant, req_ready=0 and req_valid is ignored.
   Release -> dout_valid=0 next cycle, then a new request is accepted.
6. Assert rst in WAIT1 of a split load, RD_LATENCY=3.
   -> next cycle all outputs are at reset values, no dout_valid for the aborted load, and a following LW completes correctly.

Source files
------------

// File: rtl/load_ctrl_ram.sv
// load_ctrl_ram: read side of the data RAM path. Runs LB/LBU/LH/LHU/LW
// loads, issuing one word read (two when the access straddles a word
// boundary), waiting the fixed RAM latency and returning the extended value.
module load_ctrl_ram #(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic              TYPE_B,
  input  logic              TYPE_HB,
  input  logic              UNSIGNED,
  output logic              ram_re,
  output logic [ADDR_W-3:0] ram_addr,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, RD0, WAIT0, RD1, WAIT1, DONE} state_t;

  localparam logic [2:0]        LAT_LAST = 3'(RD_LATENCY - 1);
  localparam logic [ADDR_W-3:0] WORD_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        lat_cnt;
  logic              lat_done;
  logic              accept;

  logic              in_byte;
  logic              in_half;
  logic              in_word;
  logic              in_split;

  logic [ADDR_W-3:0] word_addr;
  logic [1:0]        off;
  logic              is_byte;
  logic              is_half;
  logic              is_unsigned;
  logic              is_split;
  logic [31:0]       w0;
  logic [31:0]       w1;

  logic [63:0]       both_words;
  logic [31:0]       shifted;

  assign lat_done = (lat_cnt == LAT_LAST);
  assign accept   = (state == IDLE) && req_valid && !rst;

  // Size decode of the incoming request; TYPE_B alone still means byte.
  always_comb begin
    in_byte  = TYPE_B;
    in_half  = TYPE_HB && !TYPE_B;
    in_word  = !TYPE_B && !TYPE_HB;
    in_split = (in_half && (addr[1:0] == 2'd3)) || (in_word && (addr[1:0] != 2'd0));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/RAM strobe outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = '0;
    dout_valid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (accept) state_nxt = RD0;
      end
      RD0: begin
        ram_re    = 1'b1;
        ram_addr  = word_addr;
        state_nxt = WAIT0;
      end
      WAIT0: begin
        if (lat_done) state_nxt = is_split ? RD1 : DONE;
      end
      RD1: begin
        ram_re    = 1'b1;
        ram_addr  = word_addr + WORD_ONE;
        state_nxt = WAIT1;
      end
      WAIT1: begin
        if (lat_done) state_nxt = DONE;
      end
      DONE: begin
        dout_valid = 1'b1;
        if (dout_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, latency counter and word capture at the end of each wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_addr   <= '0;
      off         <= '0;
      is_byte     <= 1'b0;
      is_half     <= 1'b0;
      is_unsigned <= 1'b0;
      is_split    <= 1'b0;
      lat_cnt     <= '0;
      w0          <= '0;
      w1          <= '0;
    end else begin
      if (accept) begin
        word_addr   <= addr[ADDR_W-1:2];
        off         <= addr[1:0];
        is_byte     <= in_byte;
        is_half     <= in_half;
        is_unsigned <= UNSIGNED;
        is_split    <= in_split;
        w1          <= '0;
      end
      case (state)
        RD0, RD1: lat_cnt <= '0;
        WAIT0: begin
          if (lat_done) w0 <= ram_rdata;
          else          lat_cnt <= lat_cnt + 3'd1;
        end
        WAIT1: begin
          if (lat_done) w1 <= ram_rdata;
          else          lat_cnt <= lat_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Align the addressed bytes down to bit 0 and extend to 32 bits.
  always_comb begin
    both_words = {w1, w0};
    shifted    = 32'(both_words >> {off, 3'b000});
    if (is_byte) begin
      dout = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
    end else if (is_half) begin
      dout = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
    end else begin
      dout = shifted;
    end
  end

endmodule
